// File: rtl/uart_out.sv
// uart_out: memory-mapped serial transmitter with a small transmit FIFO.
// TXDATA (0x001) queues a byte. STATUS (0x002) reports busy/full/overflow;
// writing it clears overflow. Reads return one cycle later, matching memory timing.
// Optional feature: define UART_OUT_PARITY_EN to insert an even parity bit
// between the last data bit and the stop bit.
module uart_out #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  mem_addr,
  input  logic [15:0] wr_data,
  input  logic        mem_wr,
  output logic [15:0] rd_data_io,
  output logic        rd_sel,
  output logic        uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] TIMER_MAX     = TW'(CLK_DIV - 1);
  localparam logic [CW-1:0] FIFO_FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [9:0]    ADDR_TXDATA   = 10'h001;
  localparam logic [9:0]    ADDR_STATUS   = 10'h002;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_OUT_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_bitCnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic          r_tx;

  logic [15:0]   r_rdData;
  logic          r_rdSel;

  state_t        w_nextState;
  logic [TW-1:0] w_nextTimer;
  logic [2:0]    w_nextBitCnt;
  logic [7:0]    w_nextShift;
  logic          w_nextParity;
  logic          w_nextTx;
  logic          w_pop;
  logic          w_push;
  logic          w_pushOk;
  logic          w_full;
  logic          w_empty;
  logic          w_timerDone;
  logic          w_busy;
  logic [7:0]    w_head;
  logic [15:0]   w_status;
  logic          w_unusedHi;

  // Only the low byte of a TXDATA write is transmitted; the upper byte is
  // folded into a deliberately unused net so the intent is explicit.
  assign w_unusedHi = ^wr_data[15:8];

  assign w_push      = mem_wr && (mem_addr == ADDR_TXDATA);
  assign w_full      = (r_count == FIFO_FULL_CNT);
  assign w_empty     = (r_count == '0);
  assign w_pushOk    = w_push && !w_full;
  assign w_head      = r_fifo[r_rdPtr];
  assign w_timerDone = (r_timer == TIMER_MAX);
  assign w_busy      = !w_empty || (r_state != S_IDLE);
  assign w_status    = {13'b0, r_overflow, w_full, w_busy};

  assign uart_tx    = r_tx;
  assign rd_data_io = r_rdData;
  assign rd_sel     = r_rdSel;

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (!rst && w_pushOk) begin
      r_fifo[r_wrPtr] <= wr_data[7:0];
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pushOk) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_pushOk, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_full) begin
        r_overflow <= 1'b1;
      end else if (mem_wr && (mem_addr == ADDR_STATUS)) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Transmit FSM next-state logic; the line level is derived from the next state
  // so uart_tx can be a plain register.
  always_comb begin
    w_nextState  = r_state;
    w_nextTimer  = r_timer;
    w_nextBitCnt = r_bitCnt;
    w_nextShift  = r_shift;
    w_nextParity = r_parity;
    w_pop        = 1'b0;
    w_nextTx     = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_nextShift  = w_head;
          w_nextParity = ^w_head;
          w_nextTimer  = '0;
          w_nextBitCnt = '0;
          w_nextState  = S_START;
        end
      end
      S_START: begin
        if (w_timerDone) begin
          w_nextTimer = '0;
          w_nextState = S_DATA;
        end else begin
          w_nextTimer = r_timer + 1'b1;
        end
      end
      S_DATA: begin
        if (w_timerDone) begin
          w_nextTimer = '0;
          if (r_bitCnt == 3'd7) begin
            w_nextBitCnt = '0;
`ifdef UART_OUT_PARITY_EN
            w_nextState  = S_PARITY;
`else
            w_nextState  = S_STOP;
`endif
          end else begin
            w_nextBitCnt = r_bitCnt + 1'b1;
            w_nextShift  = {1'b0, r_shift[7:1]};
          end
        end else begin
          w_nextTimer = r_timer + 1'b1;
        end
      end
`ifdef UART_OUT_PARITY_EN
      S_PARITY: begin
        if (w_timerDone) begin
          w_nextTimer = '0;
          w_nextState = S_STOP;
        end else begin
          w_nextTimer = r_timer + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_timerDone) begin
          w_nextTimer = '0;
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_nextShift  = w_head;
            w_nextParity = ^w_head;
            w_nextBitCnt = '0;
            w_nextState  = S_START;
          end else begin
            w_nextState = S_IDLE;
          end
        end else begin
          w_nextTimer = r_timer + 1'b1;
        end
      end
      default: begin
        w_nextState = S_IDLE;
        w_nextTimer = '0;
      end
    endcase

    case (w_nextState)
      S_START: w_nextTx = 1'b0;
      S_DATA:  w_nextTx = w_nextShift[0];
`ifdef UART_OUT_PARITY_EN
      S_PARITY: w_nextTx = w_nextParity;
`endif
      default: w_nextTx = 1'b1;
    endcase
  end

  // Transmit FSM state register; reset abandons any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
    end else begin
      r_state  <= w_nextState;
      r_timer  <= w_nextTimer;
      r_bitCnt <= w_nextBitCnt;
      r_shift  <= w_nextShift;
      r_parity <= w_nextParity;
      r_tx     <= w_nextTx;
    end
  end

  // Registered read port: claims the bus only for reads of the two I/O addresses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdData <= '0;
      r_rdSel  <= 1'b0;
    end else if (!mem_wr && (mem_addr == ADDR_TXDATA)) begin
      r_rdData <= '0;
      r_rdSel  <= 1'b1;
    end else if (!mem_wr && (mem_addr == ADDR_STATUS)) begin
      r_rdData <= w_status;
      r_rdSel  <= 1'b1;
    end else begin
      r_rdData <= '0;
      r_rdSel  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_out.sv
// tb_uart_out: randomized self-checking bench for uart_out. Expected serial
// waveforms are built bit by bit from the byte values (start, LSB-first data,
// optional parity, stop), and status timing is derived from frame arithmetic.
// Honours UART_OUT_PARITY_EN when defined.
module tb_uart_out;

  localparam int CD    = 4;
  localparam int DEPTH = 8;
`ifdef UART_OUT_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME = FRAME_BITS * CD;
  localparam logic [9:0] IDLE_ADDR = 10'h3FF;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  mem_addr;
  logic [15:0] wr_data;
  logic        mem_wr;
  logic [15:0] rd_data_io;
  logic        rd_sel;
  logic        uart_tx;

  int compared   = 0;
  int mismatched = 0;
  int cycleCnt   = 0;
  bit expWave[$];

  uart_out #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .mem_addr(mem_addr),
    .wr_data(wr_data),
    .mem_wr(mem_wr),
    .rd_data_io(rd_data_io),
    .rd_sel(rd_sel),
    .uart_tx(uart_tx)
  );

  // Free-running clock.
  initial forever #5 clk = ~clk;

  // Edge counter so tests can reason about absolute edge numbers.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic busWrite(input logic [9:0] addr, input logic [15:0] data, output int edgeNum);
    @(negedge clk);
    mem_addr = addr;
    wr_data  = data;
    mem_wr   = 1'b1;
    @(posedge clk);
    #1;
    edgeNum  = cycleCnt;
    mem_wr   = 1'b0;
    mem_addr = IDLE_ADDR;
  endtask

  task automatic busRead(input logic [9:0] addr, output logic [15:0] data, output logic sel,
                         output int edgeNum);
    @(negedge clk);
    mem_addr = addr;
    mem_wr   = 1'b0;
    @(posedge clk);
    #1;
    edgeNum  = cycleCnt;
    data     = rd_data_io;
    sel      = rd_sel;
    mem_addr = IDLE_ADDR;
  endtask

  // Appends the ideal line waveform of one frame carrying byte b.
  task automatic appendFrame(input logic [7:0] b);
    repeat (CD) expWave.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (CD) expWave.push_back(b[i]);
    end
`ifdef UART_OUT_PARITY_EN
    repeat (CD) expWave.push_back(^b);
`endif
    repeat (CD) expWave.push_back(1'b1);
  endtask

  // Follows the first bus write edge, compares the line against expWave, then
  // checks busy is still set at the last stop edge and clear one edge later.
  task automatic checkWave(input string name);
    int errs = 0;
    int firstBad = -1;
    bit wantBit = 1'b0;
    logic gotBit = 1'b0;
    @(negedge clk);
    @(posedge clk);
    for (int i = 0; i < expWave.size(); i++) begin
      @(negedge clk);
      if (uart_tx !== expWave[i]) begin
        if (errs == 0) begin
          firstBad = i;
          wantBit  = expWave[i];
          gotBit   = uart_tx;
        end
        errs++;
      end
    end
    mem_wr   = 1'b0;
    mem_addr = 10'h002;
    compared++;
    if (errs != 0) begin
      mismatched++;
      $display("[TB] FAIL wave_%s: %0d of %0d samples wrong, first at %0d got %b want %b",
               name, errs, expWave.size(), firstBad, gotBit, wantBit);
    end
    @(posedge clk);
    #1;
    compared++;
    if (rd_data_io !== 16'h0001) begin
      mismatched++;
      $display("[TB] FAIL busy_last_stop_%s: got %h want 0001", name, rd_data_io);
    end
    @(posedge clk);
    #1;
    compared++;
    if (rd_data_io !== 16'h0000) begin
      mismatched++;
      $display("[TB] FAIL idle_after_%s: got %h want 0000", name, rd_data_io);
    end
    mem_addr = IDLE_ADDR;
  endtask

  task automatic test_reset;
    logic [15:0] d;
    logic s;
    int e;
    rst      = 1'b1;
    mem_wr   = 1'b0;
    mem_addr = IDLE_ADDR;
    wr_data  = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (uart_tx !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_tx: got %b want 1", uart_tx);
    end
    compared++;
    if (rd_sel !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_rd_sel: got %b want 0", rd_sel);
    end
    compared++;
    if (rd_data_io !== 16'h0000) begin
      mismatched++;
      $display("[TB] FAIL reset_rd_data: got %h want 0000", rd_data_io);
    end
    rst = 1'b0;
    busRead(10'h002, d, s, e);
    compared++;
    if (d !== 16'h0000 || s !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_status: got %h sel %b want 0000 sel 1", d, s);
    end
  endtask

  task automatic test_reads;
    logic [15:0] d;
    logic s;
    int e;
    busRead(10'h001, d, s, e);
    compared++;
    if (d !== 16'h0000 || s !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL read_txdata: got %h sel %b want 0000 sel 1", d, s);
    end
    busRead(10'h100, d, s, e);
    compared++;
    if (s !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL read_mem_sel: got %b want 0", s);
    end
    busRead(10'h003, d, s, e);
    compared++;
    if (s !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL read_003_sel: got %b want 0", s);
    end
    busRead(10'h002, d, s, e);
    busWrite(10'h002, 16'hFFFF, e);
    compared++;
    if (rd_sel !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL write_clears_sel: got %b want 0", rd_sel);
    end
  endtask

  task automatic test_single(input logic [15:0] word, input string name);
    int e;
    expWave.delete();
    expWave.push_back(1'b1);
    appendFrame(word[7:0]);
    fork
      busWrite(10'h001, word, e);
      checkWave(name);
    join
  endtask

  task automatic test_back_to_back;
    expWave.delete();
    expWave.push_back(1'b1);
    appendFrame(8'h55);
    appendFrame(8'hAA);
    fork
      begin
        int e;
        logic [15:0] d;
        logic s;
        busWrite(10'h001, 16'h0055, e);
        busWrite(10'h001, 16'h00AA, e);
        busRead(10'h002, d, s, e);
        compared++;
        if (d !== 16'h0001 || s !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL status_busy: got %h sel %b want 0001 sel 1", d, s);
        end
        busRead(10'h001, d, s, e);
        compared++;
        if (d !== 16'h0000 || s !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL read_txdata_busy: got %h sel %b want 0000 sel 1", d, s);
        end
      end
      checkWave("b2b");
    join
  endtask

  task automatic test_random;
    for (int round = 0; round < 3; round++) begin
      logic [7:0] bytes[$];
      int n;
      n = $urandom_range(2, 6);
      bytes.delete();
      expWave.delete();
      expWave.push_back(1'b1);
      for (int i = 0; i < n; i++) begin
        bytes.push_back(8'($urandom));
        appendFrame(bytes[i]);
      end
      fork
        begin
          int e;
          for (int i = 0; i < n; i++) begin
            busWrite(10'h001, {8'($urandom), bytes[i]}, e);
          end
        end
        checkWave($sformatf("rand%0d", round));
      join
    end
  endtask

  task automatic test_overflow;
    logic [15:0] d;
    logic s;
    int e;
    int firstEdge = 0;
    int idleEdge = -1;
    int expEdge;
    for (int i = 0; i < 10; i++) begin
      busWrite(10'h001, 16'(32'h30 + i), e);
      if (i == 0) firstEdge = e;
    end
    busRead(10'h002, d, s, e);
    compared++;
    if (d !== 16'h0007) begin
      mismatched++;
      $display("[TB] FAIL status_overflow: got %h want 0007", d);
    end
    busWrite(10'h002, 16'($urandom), e);
    busRead(10'h002, d, s, e);
    compared++;
    if (d !== 16'h0003) begin
      mismatched++;
      $display("[TB] FAIL status_ovf_cleared: got %h want 0003", d);
    end
    for (int k = 0; k < 2000; k++) begin
      busRead(10'h002, d, s, e);
      if (d[0] === 1'b0) begin
        idleEdge = e;
        break;
      end
    end
    expEdge = firstEdge + 1 + 9 * FRAME + 1;
    compared++;
    if (idleEdge != expEdge) begin
      mismatched++;
      $display("[TB] FAIL overflow_drain_edge: got %0d want %0d", idleEdge, expEdge);
    end
    compared++;
    if (d !== 16'h0000) begin
      mismatched++;
      $display("[TB] FAIL status_after_drain: got %h want 0000", d);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] d;
    logic s;
    int e;
    int lowCnt = 0;
    logic startBit = 1'b1;
    busWrite(10'h001, 16'h000F, e);
    for (int k = 1; k <= 4 * CD + 2; k++) begin
      @(negedge clk);
      if (k == 2) startBit = uart_tx;
    end
    compared++;
    if (startBit !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mid_frame_start: got %b want 0", startBit);
    end
    rst      = 1'b1;
    mem_wr   = 1'b0;
    mem_addr = 10'h002;
    @(posedge clk);
    #1;
    compared++;
    if (uart_tx !== 1'b1 || rd_sel !== 1'b0 || rd_data_io !== 16'h0000) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_outputs: got tx %b sel %b data %h want 1 0 0000",
               uart_tx, rd_sel, rd_data_io);
    end
    mem_wr   = 1'b1;
    mem_addr = 10'h001;
    wr_data  = 16'h0055;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    mem_wr   = 1'b0;
    mem_addr = IDLE_ADDR;
    busRead(10'h002, d, s, e);
    compared++;
    if (d !== 16'h0000) begin
      mismatched++;
      $display("[TB] FAIL status_after_mid_reset: got %h want 0000", d);
    end
    repeat (3 * FRAME) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lowCnt++;
    end
    compared++;
    if (lowCnt != 0) begin
      mismatched++;
      $display("[TB] FAIL line_quiet_after_reset: got %0d non-idle samples want 0", lowCnt);
    end
  endtask

  // Test sequence.
  initial begin
    test_reset();
    test_reads();
    test_single(16'h0041, "x41");
    test_single(16'h0007, "x07");
    test_back_to_back();
    test_random();
    test_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
